// File: rtl/card_shoe_dealer_pkg.sv
// Shared types and constants for the card shoe: FSM states, deck geometry, LFSR taps, rank->value map.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package card_shoe_dealer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_GAP     = 2'd3
    } deal_state_t;

    // Deck slot address: two suit bits above four rank bits.
    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } slot_t;

    localparam int DECK_SIZE  = 52;
    localparam int RANK_COUNT = 13;

    // Galois right-shift taps for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Ranks 13..15 of every suit are not real cards and stay marked dealt forever.
    localparam logic [63:0] PAD_SLOTS = 64'hE000_E000_E000_E000;

    // Blackjack value of a rank: ace is configurable, pip cards count rank+1, faces count 10.
    function automatic logic [4:0] rank_value(input logic [3:0] rank, input logic [4:0] ace_value);
        logic [4:0] v;
        v = 5'd0;
        if (rank == 4'd0) begin
            v = ace_value;
        end else if (rank <= 4'd8) begin
            v = {1'b0, rank} + 5'd1;
        end else if (rank < 4'(RANK_COUNT)) begin
            v = 5'd10;
        end
        return v;
    endfunction

endpackage

// File: rtl/card_shoe_dealer_lfsr16.sv
// Free-running 16-bit Galois LFSR with a synchronous load of {INIT_HI, seed}.
// Latency: load or step takes effect on the next clock edge.
// Backpressure: none; steps every cycle that is not a load.
module card_lfsr16
    import card_shoe_dealer_pkg::*;
#(
    parameter logic [10:0] INIT_HI = 11'h5A5
) (
    input  logic       i_clk,
    input  logic       i_load,
    input  logic [4:0] i_seed,
    output logic [5:0] o_draw
);

    logic [15:0] r_state;

    // Reload from the seed when asked, otherwise advance one Galois step.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_state <= {INIT_HI, i_seed};
        end else begin
            r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // Only the low six bits are ever used, as the starting slot of a search.
    assign o_draw = r_state[5:0];

endmodule

// File: rtl/card_shoe_dealer.sv
// Deals one card at a time from a 52-card deck without replacement, LFSR-picked slot plus linear probe.
// Latency: submit rises 2 cycles after accept on a first-probe hit, 65 cycles worst case.
// Backpressure: ready is high only in IDLE; deal_req at any other time is dropped, not queued.
module card_shoe_dealer
    import card_shoe_dealer_pkg::*;
#(
    parameter logic [4:0]  ACE_VALUE    = 5'd11,
    parameter logic [10:0] LFSR_INIT_HI = 11'h5A5,
    parameter int          GAP_CYCLES   = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [4:0] i_seed,
    input  logic       i_deal_req,
    input  logic       i_shuffle,
    output logic       o_ready,
    output logic [4:0] o_card_out,
    output logic       o_submit,
    output logic [1:0] o_card_suit,
    output logic [3:0] o_card_rank,
    output logic [5:0] o_cards_left,
    output logic       o_deck_empty,
    output logic       o_deal_err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    deal_state_t      r_state;
    logic [63:0]      r_mask;
    logic [5:0]       r_probe;
    logic [5:0]       r_cards_left;
    logic             r_submit;
    logic [4:0]       r_card_out;
    logic [1:0]       r_card_suit;
    logic [3:0]       r_card_rank;
    logic             r_deal_err;
    logic             r_shuf_pend;
    logic [GAP_W-1:0] r_gap_cnt;

    logic             w_idle;
    logic             w_apply_shuf;
    logic             w_accept;
    logic             w_hit;
    logic [5:0]       w_draw;
    logic [5:0]       w_probe_src;
    slot_t            w_slot;

    assign w_idle       = (r_state == ST_IDLE);
    // A pending shuffle, or one arriving while idle, is applied at this edge.
    assign w_apply_shuf = w_idle & (r_shuf_pend | i_shuffle);
    // A same-cycle shuffle refills the deck first, so the deal is always possible then.
    assign w_accept     = w_idle & ~r_shuf_pend & i_deal_req & (i_shuffle | (r_cards_left != 6'd0));
    // With a same-cycle shuffle the first probe comes from the freshly reseeded LFSR value.
    assign w_probe_src  = i_shuffle ? {LFSR_INIT_HI[0], i_seed} : w_draw;
    assign w_hit        = ~r_mask[r_probe];
    assign w_slot       = slot_t'(r_probe);

    card_lfsr16 #(
        .INIT_HI (LFSR_INIT_HI)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_load (i_reset | w_apply_shuf),
        .i_seed (i_seed),
        .o_draw (w_draw)
    );

    // Deal FSM with the deck mask, probe pointer and registered card outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_mask       <= PAD_SLOTS;
            r_probe      <= 6'd0;
            r_cards_left <= 6'(DECK_SIZE);
            r_submit     <= 1'b0;
            r_card_out   <= 5'd0;
            r_card_suit  <= 2'd0;
            r_card_rank  <= 4'd0;
            r_deal_err   <= 1'b0;
            r_shuf_pend  <= 1'b0;
            r_gap_cnt    <= '0;
        end else begin
            r_submit   <= 1'b0;
            r_deal_err <= 1'b0;
            if (!w_idle && i_shuffle) begin
                r_shuf_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_apply_shuf) begin
                        r_mask       <= PAD_SLOTS;
                        r_cards_left <= 6'(DECK_SIZE);
                        r_shuf_pend  <= 1'b0;
                    end
                    if (w_accept) begin
                        r_probe <= w_probe_src;
                        r_state <= ST_SEARCH;
                    end else if (!r_shuf_pend && i_deal_req) begin
                        r_deal_err <= 1'b1;
                    end
                end
                ST_SEARCH: begin
                    if (w_hit) begin
                        r_mask[r_probe] <= 1'b1;
                        if (r_cards_left != 6'd0) begin
                            r_cards_left <= r_cards_left - 6'd1;
                        end
                        r_card_suit <= w_slot.suit;
                        r_card_rank <= w_slot.rank;
                        r_card_out  <= rank_value(w_slot.rank, ACE_VALUE);
                        r_submit    <= 1'b1;
                        r_state     <= ST_PRESENT;
                    end else begin
                        r_probe <= r_probe + 6'd1;
                    end
                end
                ST_PRESENT: begin
                    r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                    r_state   <= ST_GAP;
                end
                default: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    // The idle cycle that applies a pending shuffle does not take a deal.
    assign o_ready      = w_idle & ~r_shuf_pend;
    assign o_submit     = r_submit;
    assign o_card_out   = r_card_out;
    assign o_card_suit  = r_card_suit;
    assign o_card_rank  = r_card_rank;
    assign o_cards_left = r_cards_left;
    assign o_deck_empty = (r_cards_left == 6'd0);
    assign o_deal_err   = r_deal_err;

endmodule

// File: tb/tb_card_shoe_dealer.sv
// Bench for card_shoe_dealer: transaction-level deck model checked every cycle, plus directed scenarios.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_card_shoe_dealer;

    localparam logic [10:0] HI = 11'h5A5;

    logic       clk = 1'b0;
    logic       reset, deal_req, shuffle;
    logic [4:0] seed;
    logic       o_ready, o_submit, o_deck_empty, o_deal_err;
    logic [4:0] o_card_out;
    logic [1:0] o_card_suit;
    logic [3:0] o_card_rank;
    logic [5:0] o_cards_left;

    always #5 clk = ~clk;

    card_shoe_dealer dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_seed       (seed),
        .i_deal_req   (deal_req),
        .i_shuffle    (shuffle),
        .o_ready      (o_ready),
        .o_card_out   (o_card_out),
        .o_submit     (o_submit),
        .o_card_suit  (o_card_suit),
        .o_card_rank  (o_card_rank),
        .o_cards_left (o_cards_left),
        .o_deck_empty (o_deck_empty),
        .o_deal_err   (o_deal_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: deck as a 4x13 array, timing as cycle stamps ----------------
    bit          m_valid = 1'b0;
    bit          dealt[4][13];
    int          m_left, idle_from, sub_cyc;
    bit          pend;
    logic [15:0] m_lfsr;
    int          nxt_suit, nxt_rank;
    bit          e_ready, e_submit, e_err;
    int          e_card, e_suit, e_rank;
    bit          prev_sub = 1'b0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ ({16{l[0]}} & 16'hB400);
    endfunction

    function automatic int card_val(input int rank);
        if (rank == 0) return 11;
        if (rank <= 8) return rank + 1;
        return 10;
    endfunction

    task automatic clear_deck();
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 13; r++) dealt[s][r] = 1'b0;
        m_left = 52;
    endtask

    task automatic deal_from(input int p);
        bit found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            int slot = (p + n) % 64;
            int s = slot / 16;
            int r = slot % 16;
            if (r < 13 && !dealt[s][r]) begin
                found = 1'b1;
                dealt[s][r] = 1'b1;
                nxt_suit = s;
                nxt_rank = r;
                sub_cyc = cyc + n + 2;
                idle_from = cyc + n + 4;
            end
        end
    endtask

    task automatic model_step();
        logic [15:0] cur, ld;
        bit idle;
        int p;
        e_err = 1'b0;
        ld = {HI, seed};
        if (reset) begin
            m_valid = 1'b1;
            clear_deck();
            m_lfsr = ld;
            idle_from = cyc + 1;
            sub_cyc = -1;
            pend = 1'b0;
            e_card = 0; e_suit = 0; e_rank = 0;
        end else if (m_valid) begin
            idle = (cyc >= idle_from);
            cur = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            if (idle && pend) begin
                clear_deck();
                m_lfsr = ld;
                pend = 1'b0;
            end else if (idle) begin
                p = int'(cur[5:0]);
                if (shuffle) begin
                    clear_deck();
                    m_lfsr = ld;
                    p = int'(ld[5:0]);
                end
                if (deal_req && m_left != 0) deal_from(p);
                else if (deal_req) e_err = 1'b1;
            end else if (shuffle) begin
                pend = 1'b1;
            end
        end
        cyc++;
        if (cyc == sub_cyc) begin
            m_left--;
            e_card = card_val(nxt_rank);
            e_suit = nxt_suit;
            e_rank = nxt_rank;
        end
        e_submit = (cyc == sub_cyc);
        e_ready = (cyc >= idle_from) && !pend;
    endtask

    // Compare every cycle against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (m_valid) begin
            check("ready", o_ready, e_ready);
            check("submit", o_submit, e_submit);
            check("deal_err", o_deal_err, e_err);
            check("cards_left", o_cards_left, m_left);
            check("deck_empty", o_deck_empty, m_left == 0);
            check("card_out", o_card_out, e_card);
            check("card_suit", o_card_suit, e_suit);
            check("card_rank", o_card_rank, e_rank);
            check("submit_b2b", prev_sub & o_submit, 0);
            prev_sub = o_submit;
        end
        model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (!o_ready && t < 200) begin tick(); t++; end
        check({name, "_ready_timeout"}, o_ready, 1);
    endtask

    int hist[32];
    bit seen[4][16];
    int nsub, idle_cnt, t;
    int run_cards[2][10];
    bit got_sub;

    initial begin
        reset = 1'b1; seed = 5'd1; deal_req = 1'b0; shuffle = 1'b0;
        for (int i = 0; i < 32; i++) hist[i] = 0;
        for (int s = 0; s < 4; s++) for (int r = 0; r < 16; r++) seen[s][r] = 1'b0;
        repeat (3) tick();

        // Reset values.
        reset = 1'b0;
        check("rst_ready", o_ready, 1);
        check("rst_left", o_cards_left, 52);
        check("rst_submit", o_submit, 0);
        check("rst_card", o_card_out, 0);
        check("rst_empty", o_deck_empty, 0);

        // First deal after seed 1: lfsr 0xB4A1 -> probe 33 -> suit 2 rank 1, value 2.
        deal_req = 1'b1;
        tick();
        tick();
        check("first_submit", o_submit, 1);
        check("first_suit", o_card_suit, 2);
        check("first_rank", o_card_rank, 1);
        check("first_value", o_card_out, 2);
        check("first_left", o_cards_left, 51);
        nsub = 1;
        seen[2][1] = 1'b1;
        hist[o_card_out]++;

        // Drain the deck with deal_req held high.
        t = 0;
        while (nsub < 52 && t < 5000) begin
            tick(); t++;
            if (o_submit) begin
                check("unique_card", seen[o_card_suit][o_card_rank], 0);
                seen[o_card_suit][o_card_rank] = 1'b1;
                hist[o_card_out]++;
                nsub++;
                check("left_seq", o_cards_left, 52 - nsub);
            end
        end
        deal_req = 1'b0;
        check("deal52_count", nsub, 52);
        wait_ready("drain");
        check("drain_left", o_cards_left, 0);
        check("drain_empty", o_deck_empty, 1);
        check("hist_10", hist[10], 16);
        check("hist_11", hist[11], 4);
        for (int v = 2; v <= 9; v++) check("hist_pip", hist[v], 4);

        // Deal on an empty deck: one error pulse, no card.
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        check("empty_err", o_deal_err, 1);
        check("empty_ready", o_ready, 1);
        tick();
        check("empty_err_drop", o_deal_err, 0);
        nsub = 0;
        for (int i = 0; i < 5; i++) begin
            nsub += o_submit;
            tick();
        end
        check("empty_no_submit", nsub, 0);

        // Shuffle in IDLE, then hold deal_req for 200 cycles.
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        check("shuffle_left", o_cards_left, 52);
        deal_req = 1'b1;
        nsub = 0; idle_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            idle_cnt += o_ready;
            tick();
            nsub += o_submit;
        end
        deal_req = 1'b0;
        check("per_visit", (idle_cnt - nsub >= 0) && (idle_cnt - nsub <= 1), 1);
        wait_ready("hold");

        // Shuffle during PRESENT: card delivered, deck refilled one cycle after IDLE return.
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        got_sub = 1'b0; t = 0;
        while (!o_submit && t < 100) begin tick(); t++; end
        got_sub = o_submit;
        check("pres_card_delivered", got_sub, 1);
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        tick();
        check("pend_idle_ready", o_ready, 0);
        tick();
        check("pend_left", o_cards_left, 52);
        check("pend_ready", o_ready, 1);

        // Same seed, two runs of ten deals.
        for (int run = 0; run < 2; run++) begin
            reset = 1'b1; seed = 5'd7;
            tick(); tick();
            reset = 1'b0;
            deal_req = 1'b1;
            nsub = 0; t = 0;
            while (nsub < 10 && t < 1000) begin
                tick(); t++;
                if (o_submit) begin run_cards[run][nsub] = int'(o_card_out); nsub++; end
            end
            deal_req = 1'b0;
            check("rerun_count", nsub, 10);
            wait_ready("rerun");
        end
        for (int i = 0; i < 10; i++) check("rerun_same", run_cards[1][i], run_cards[0][i]);

        // Reset during SEARCH aborts the deal.
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", o_ready, 1);
        check("abort_submit", o_submit, 0);
        check("abort_left", o_cards_left, 52);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            deal_req = 1'($urandom_range(0, 1));
            shuffle = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 299) == 0);
            seed = 5'($urandom);
            tick();
        end
        deal_req = 1'b0; shuffle = 1'b0; reset = 1'b0;
        repeat (80) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
